// File: rtl/oc8051_shared_mem_responder_pkg.sv
// Shared types and constants for the oc8051 shared-bus memory responder.
// Holds the FSM encoding, the privilege encoding and the range-fault read value.
package oc8051_shared_mem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2,
        StRec  = 2'd3
    } mr_state_e;

    localparam logic       PrivHi  = 1'b1;
    localparam logic [7:0] MrBadRd = 8'hFF;

    function automatic logic in_window(input logic [15:0] a,
                                       input logic [15:0] base,
                                       input logic [15:0] top);
        return (a >= base) && (a <= top);
    endfunction

endpackage

// File: rtl/oc8051_resp_ram.sv
// Single-port synchronous byte RAM with a registered read port.
// A write cycle leaves the read register untouched.
module oc8051_resp_ram #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [2**ADDR_W];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/oc8051_shared_mem_responder.sv
// Target-side responder for the dual-core shared-bus port: one request at a time,
// programmable wait states, privileged write-protect window and a sticky fault log.
module oc8051_shared_mem_responder
    import oc8051_shared_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [15:0] PROT_BASE   = 16'h00C0,
    parameter logic [15:0] PROT_TOP    = 16'h00FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        priv_lvl,
    input  logic [15:0] dpc_ot,
    output logic        ack,
    output logic [7:0]  data_out,
    output logic        viol,
    output logic [15:0] viol_pc,
    output logic [15:0] viol_addr
);

    localparam logic [3:0] WaitInit = 4'(WAIT_STATES - 1);

    mr_state_e   state_q;
    logic [3:0]  cnt_q;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        priv_q;
    logic [15:0] pc_q;
    logic        range_q;
    logic        ack_q;
    logic        viol_q;
    logic [7:0]  dout_q;
    logic [15:0] vpc_q;
    logic [15:0] vaddr_q;

    logic        in_idle;
    logic        req_wr;
    logic [15:0] req_addr;
    logic        req_priv;
    logic [15:0] req_pc;
    logic        range_flt;
    logic        prot_flt;
    logic        go_ack;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic [7:0]  rd_val;

    // In IDLE the request is still on the bus; afterwards only the captured copy counts.
    always_comb begin
        in_idle   = (state_q == StIdle);
        req_wr    = in_idle ? wr       : wr_q;
        req_addr  = in_idle ? addr     : addr_q;
        req_priv  = in_idle ? priv_lvl : priv_q;
        req_pc    = in_idle ? dpc_ot   : pc_q;
        range_flt = (req_addr >> ADDR_W) != '0;
        prot_flt  = req_wr && (req_priv != PrivHi) && in_window(req_addr, PROT_BASE, PROT_TOP);
        go_ack    = (in_idle && stb && (WAIT_STATES == 0)) ||
                    ((state_q == StWait) && (cnt_q == 4'd0));
        ram_we    = (state_q == StAck) && wr_q && !viol_q;
        ram_en    = go_ack || ram_we;
        rd_val    = range_q ? MrBadRd : ram_rdata;
    end

    oc8051_resp_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (req_addr[ADDR_W-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            priv_q  <= 1'b0;
            pc_q    <= 16'h0000;
            range_q <= 1'b0;
            ack_q   <= 1'b0;
            viol_q  <= 1'b0;
            dout_q  <= 8'h00;
            vpc_q   <= 16'h0000;
            vaddr_q <= 16'h0000;
        end else begin
            ack_q  <= 1'b0;
            viol_q <= 1'b0;
            if (go_ack) begin
                ack_q   <= 1'b1;
                viol_q  <= range_flt || prot_flt;
                range_q <= range_flt;
                if (range_flt || prot_flt) begin
                    vpc_q   <= req_pc;
                    vaddr_q <= req_addr;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (stb) begin
                        wr_q    <= wr;
                        addr_q  <= addr;
                        wdata_q <= data_in;
                        priv_q  <= priv_lvl;
                        pc_q    <= dpc_ot;
                        if (WAIT_STATES == 0) begin
                            state_q <= StAck;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= WaitInit;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StAck;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StAck: begin
                    state_q <= StRec;
                    if (!wr_q) begin
                        dout_q <= rd_val;
                    end
                end
                StRec: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read data is shown straight from the RAM in the ack cycle, then held.
    always_comb begin
        ack       = ack_q;
        viol      = viol_q;
        viol_pc   = vpc_q;
        viol_addr = vaddr_q;
        data_out  = (ack_q && !wr_q) ? rd_val : dout_q;
    end

endmodule

// File: tb/tb_oc8051_shared_mem_responder.sv
// Bench: two responders (WAIT_STATES=1 and 0) share one stimulus stream and are checked
// every cycle against a transaction-level latency/memory model, plus directed literal checks.
module tb_oc8051_shared_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        priv_lvl;
    logic [15:0] dpc_ot;

    logic [1:0]  ack_w;
    logic [1:0]  viol_w;
    logic [7:0]  dout_w  [2];
    logic [15:0] vpc_w   [2];
    logic [15:0] vaddr_w [2];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    oc8051_shared_mem_responder #(
        .ADDR_W      (8),
        .WAIT_STATES (1),
        .PROT_BASE   (16'h00C0),
        .PROT_TOP    (16'h00FF)
    ) u_dut_ws1 (
        .clk       (clk),
        .rst       (rst),
        .stb       (stb),
        .wr        (wr),
        .addr      (addr),
        .data_in   (data_in),
        .priv_lvl  (priv_lvl),
        .dpc_ot    (dpc_ot),
        .ack       (ack_w[0]),
        .data_out  (dout_w[0]),
        .viol      (viol_w[0]),
        .viol_pc   (vpc_w[0]),
        .viol_addr (vaddr_w[0])
    );

    oc8051_shared_mem_responder #(
        .ADDR_W      (8),
        .WAIT_STATES (0),
        .PROT_BASE   (16'h00C0),
        .PROT_TOP    (16'h00FF)
    ) u_dut_ws0 (
        .clk       (clk),
        .rst       (rst),
        .stb       (stb),
        .wr        (wr),
        .addr      (addr),
        .data_in   (data_in),
        .priv_lvl  (priv_lvl),
        .dpc_ot    (dpc_ot),
        .ack       (ack_w[1]),
        .data_out  (dout_w[1]),
        .viol      (viol_w[1]),
        .viol_pc   (vpc_w[1]),
        .viol_addr (vaddr_w[1])
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          ack_cyc  [2];
    int          next_acc [2];
    logic        m_wr     [2];
    logic [15:0] m_addr   [2];
    logic [7:0]  m_data   [2];
    logic        m_priv   [2];
    logic [15:0] m_pc     [2];
    logic [7:0]  mem      [2][256];
    logic [7:0]  e_dout   [2];
    logic [15:0] e_vpc    [2];
    logic [15:0] e_vaddr  [2];
    bit          started = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int  ws;
            bit  e_ack;
            bit  e_viol;
            bit  rflt;
            bit  pflt;
            ws     = (i == 0) ? 1 : 0;
            e_ack  = 0;
            e_viol = 0;
            if (started) begin
                if (cyc == ack_cyc[i]) begin
                    e_ack = 1;
                    rflt  = m_addr[i] >= 16'h0100;
                    pflt  = m_wr[i] && !m_priv[i] && m_addr[i] >= 16'h00C0 && m_addr[i] <= 16'h00FF;
                    if (rflt || pflt) begin
                        e_viol     = 1;
                        e_vpc[i]   = m_pc[i];
                        e_vaddr[i] = m_addr[i];
                    end
                    if (m_wr[i] && !rflt && !pflt) mem[i][m_addr[i][7:0]] = m_data[i];
                    if (!m_wr[i]) e_dout[i] = rflt ? 8'hFF : mem[i][m_addr[i][7:0]];
                end
                check($sformatf("ack[%0d]", i), ack_w[i], e_ack);
                check($sformatf("viol[%0d]", i), viol_w[i], e_viol);
                check($sformatf("data_out[%0d]", i), dout_w[i], e_dout[i]);
                check($sformatf("viol_pc[%0d]", i), vpc_w[i], e_vpc[i]);
                check($sformatf("viol_addr[%0d]", i), vaddr_w[i], e_vaddr[i]);
            end
            if (rst) begin
                ack_cyc[i]  = -1;
                next_acc[i] = cyc + 1;
                e_dout[i]   = 8'h00;
                e_vpc[i]    = 16'h0000;
                e_vaddr[i]  = 16'h0000;
            end else if (started && stb && cyc >= next_acc[i]) begin
                m_wr[i]     = wr;
                m_addr[i]   = addr;
                m_data[i]   = data_in;
                m_priv[i]   = priv_lvl;
                m_pc[i]     = dpc_ot;
                ack_cyc[i]  = cyc + 1 + ws;
                next_acc[i] = cyc + 3 + ws;
            end
        end
        if (rst) started = 1;
    end

    // ---------------- stimulus ----------------
    task automatic xact(input logic w, input logic [15:0] a, input logic [7:0] d,
                        input logic p, input logic [15:0] pc,
                        output int lat0, output logic [7:0] d0, output logic v0,
                        output int lat1, output logic [7:0] d1, output logic v1);
        int t0;
        bit got0;
        bit got1;
        got0 = 0;
        got1 = 0;
        lat0 = -1;
        lat1 = -1;
        d0 = 8'h00;
        d1 = 8'h00;
        v0 = 1'b0;
        v1 = 1'b0;
        @(posedge clk);
        #1;
        stb = 1'b1; wr = w; addr = a; data_in = d; priv_lvl = p; dpc_ot = pc;
        t0 = cyc;
        for (int k = 0; k < 40 && !(got0 && got1); k++) begin
            @(negedge clk);
            if (ack_w[0] && !got0) begin
                got0 = 1; lat0 = cyc - t0; d0 = dout_w[0]; v0 = viol_w[0];
            end
            if (ack_w[1] && !got1) begin
                got1 = 1; lat1 = cyc - t0; d1 = dout_w[1]; v1 = viol_w[1];
            end
        end
        check("xact_ack_seen0", got0, 1);
        check("xact_ack_seen1", got1, 1);
        @(posedge clk);
        #1;
        stb = 1'b0;
    endtask

    initial begin
        int          l0;
        int          l1;
        int          t0;
        int          n0;
        int          n1;
        int          first;
        int          prev0;
        int          prev1;
        int          back2back;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic        v0;
        logic        v1;

        rst = 1'b1; stb = 1'b0; wr = 1'b0; addr = '0; data_in = '0; priv_lvl = 1'b0;
        dpc_ot = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_ack", ack_w[0], 0);
        check("reset_data_out", dout_w[0], 8'h00);
        check("reset_viol_pc", vpc_w[0], 16'h0000);

        for (int a = 0; a < 256; a++) begin
            xact(1'b1, 16'(a), 8'($urandom), 1'b1, 16'h0000, l0, d0, v0, l1, d1, v1);
        end

        // 1: unprivileged write/read outside the window
        xact(1'b1, 16'h0010, 8'h5A, 1'b0, 16'h0100, l0, d0, v0, l1, d1, v1);
        check("t1_wr_latency_ws1", l0, 2);
        check("t1_wr_viol", v0, 0);
        xact(1'b0, 16'h0010, 8'h00, 1'b0, 16'h0102, l0, d0, v0, l1, d1, v1);
        check("t1_rd_latency_ws1", l0, 2);
        check("t1_rd_data", d0, 8'h5A);
        check("t1_rd_viol", v0, 0);

        // 2: protected-window write by an unprivileged core
        xact(1'b1, 16'h00C4, 8'hEE, 1'b1, 16'h0200, l0, d0, v0, l1, d1, v1);
        check("t2_priv_wr_viol", v0, 0);
        xact(1'b1, 16'h00C4, 8'h33, 1'b0, 16'h1234, l0, d0, v0, l1, d1, v1);
        check("t2_viol", v0, 1);
        check("t2_viol_pc", vpc_w[0], 16'h1234);
        check("t2_viol_addr", vaddr_w[0], 16'h00C4);
        xact(1'b0, 16'h00C4, 8'h00, 1'b0, 16'h0204, l0, d0, v0, l1, d1, v1);
        check("t2_unpriv_rd_data", d0, 8'hEE);
        check("t2_unpriv_rd_viol", v0, 0);
        xact(1'b0, 16'h00C4, 8'h00, 1'b1, 16'h0206, l0, d0, v0, l1, d1, v1);
        check("t2_priv_rd_data", d0, 8'hEE);

        // 3: out-of-range accesses
        xact(1'b1, 16'h0000, 8'h42, 1'b1, 16'h0300, l0, d0, v0, l1, d1, v1);
        xact(1'b0, 16'h0100, 8'h00, 1'b1, 16'h0302, l0, d0, v0, l1, d1, v1);
        check("t3_rd_data", d0, 8'hFF);
        check("t3_rd_viol", v0, 1);
        check("t3_rd_viol_addr", vaddr_w[0], 16'h0100);
        check("t3_rd_data_ws0", d1, 8'hFF);
        xact(1'b1, 16'h0100, 8'h77, 1'b1, 16'h0304, l0, d0, v0, l1, d1, v1);
        check("t3_wr_viol", v0, 1);
        check("t3_wr_viol_pc", vpc_w[0], 16'h0304);
        xact(1'b0, 16'h0000, 8'h00, 1'b1, 16'h0306, l0, d0, v0, l1, d1, v1);
        check("t3_ram_unchanged", d0, 8'h42);

        // 4: stb held high, back-to-back requests
        @(posedge clk);
        #1;
        stb = 1'b1; wr = 1'b0; addr = 16'h0010; priv_lvl = 1'b1; dpc_ot = 16'h0400;
        prev0 = -1; prev1 = -1; back2back = 0; n0 = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (ack_w[0]) begin
                if (prev0 >= 0) begin
                    check("t4_spacing_ws1", cyc - prev0, 4);
                    if (cyc - prev0 == 1) back2back++;
                end
                prev0 = cyc;
                n0++;
            end
            if (ack_w[1]) begin
                if (prev1 >= 0) check("t4_spacing_ws0", cyc - prev1, 3);
                prev1 = cyc;
            end
        end
        check("t4_ack_count_ws1", n0, 6);
        check("t4_no_consecutive_ack", back2back, 0);
        @(posedge clk);
        #1;
        stb = 1'b0;
        repeat (4) @(posedge clk);

        // 5: reset during the wait cycle of a write
        xact(1'b1, 16'h0020, 8'h11, 1'b1, 16'h0500, l0, d0, v0, l1, d1, v1);
        @(posedge clk);
        #1;
        stb = 1'b1; wr = 1'b1; addr = 16'h0020; data_in = 8'hAA; priv_lvl = 1'b1;
        @(posedge clk);
        #1;
        stb = 1'b0; rst = 1'b1;
        n0 = 0;
        @(negedge clk);
        if (ack_w[0]) n0++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ack_w[0]) n0++;
        end
        check("t5_no_ack", n0, 0);
        xact(1'b0, 16'h0020, 8'h00, 1'b1, 16'h0502, l0, d0, v0, l1, d1, v1);
        check("t5_idle_latency", l0, 2);
        check("t5_pre_write_value", d0, 8'h11);

        // 6: zero wait states, stb dropped in the ack cycle
        @(posedge clk);
        #1;
        stb = 1'b1; wr = 1'b0; addr = 16'h0010; priv_lvl = 1'b1; dpc_ot = 16'h0600;
        t0 = cyc;
        @(posedge clk);
        #1;
        stb = 1'b0;
        n1 = 0; first = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack_w[1]) begin
                n1++;
                if (first < 0) first = cyc - t0;
            end
        end
        check("t6_ack_latency_ws0", first, 1);
        check("t6_single_ack", n1, 1);
        check("t6_rd_data", dout_w[1], 8'h5A);

        // randomized traffic, including unaligned stb drops and occasional resets
        for (int k = 0; k < 3000; k++) begin
            int unsigned r;
            @(posedge clk);
            #1;
            rst      = ($urandom_range(0, 199) == 0);
            stb      = ($urandom_range(0, 3) != 0);
            wr       = 1'($urandom);
            data_in  = 8'($urandom);
            priv_lvl = 1'($urandom);
            dpc_ot   = 16'($urandom);
            r        = $urandom_range(0, 9);
            if (r < 6) addr = 16'($urandom_range(0, 255));
            else if (r < 8) addr = 16'($urandom_range(16'h00C0, 16'h00FF));
            else if (r == 8) addr = 16'($urandom_range(16'h0100, 16'hFFFF));
            else begin
                case ($urandom_range(0, 3))
                    0: addr = 16'h00BF;
                    1: addr = 16'h00C0;
                    2: addr = 16'h00FF;
                    default: addr = 16'h0100;
                endcase
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0; stb = 1'b0;
        repeat (8) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
